// File: rtl/aes_pkg.sv
// aes_pkg: AES byte substitution tables and the per-transaction mode encoding
// shared by the S-box lane pipeline and its lookup sub-module.
package aes_pkg;

    typedef enum logic {
        MODE_FWD = 1'b0,
        MODE_INV = 1'b1
    } mode_e;

    localparam logic [7:0] FWD_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/sbox_lane_pipe_if.sv
// sbox_lane_pipe_if: valid/ready input and output streams plus the busy flag
// of the S-box lane pipeline, bundled so the block exposes a single bus port.
interface sbox_lane_pipe_if #(
    parameter int LANES = 16,
    parameter int TAG_W = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_mode;
    logic [8*LANES-1:0]   in_data;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [8*LANES-1:0]   out_data;
    logic [TAG_W-1:0]     out_tag;
    logic                 busy;

    // The environment: produces input transactions and consumes output ones
    modport master (
        output in_valid, in_mode, in_data, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, busy
    );

    // The pipeline itself
    modport slave (
        input  in_valid, in_mode, in_data, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, busy
    );
endinterface

// File: rtl/sbox_dual.sv
// sbox_dual: single-byte combinational AES substitution, forward or inverse.
module sbox_dual
    import aes_pkg::*;
(
    input  logic [7:0] data_i,
    input  mode_e      mode_i,
    output logic [7:0] result_o
);

    // Pick the table for this transaction's mode and look the byte up
    always_comb begin
        if (mode_i == MODE_INV) begin
            result_o = INV_SBOX[data_i];
        end else begin
            result_o = FWD_SBOX[data_i];
        end
    end

endmodule

// File: rtl/sbox_lane_pipe.sv
// sbox_lane_pipe: two-stage valid/ready pipeline. Stage A captures the input
// transaction, stage B holds the per-lane S-box result of stage A.
module sbox_lane_pipe
    import aes_pkg::*;
#(
    parameter int LANES = 16,
    parameter int TAG_W = 4
) (
    input logic             clk,
    input logic             rst_n,
    sbox_lane_pipe_if.slave bus
);
    localparam int DW = 8 * LANES;

    logic             aValid_q, aValid_d;
    mode_e            aMode_q, aMode_d;
    logic [DW-1:0]    aData_q, aData_d;
    logic [TAG_W-1:0] aTag_q, aTag_d;
    logic             bValid_q, bValid_d;
    logic [DW-1:0]    bData_q, bData_d;
    logic [TAG_W-1:0] bTag_q, bTag_d;

    logic [DW-1:0]    laneOut;
    logic             bReady;
    logic             aReady;
    logic             inFire;
    logic             aToB;

    // Ready chain: a stage can take data when empty or when it drains this cycle
    always_comb begin
        bReady = !bValid_q || bus.out_ready;
        aReady = !aValid_q || bReady;
        inFire = bus.in_valid && aReady;
        aToB   = aValid_q && bReady;
    end

    for (genvar k = 0; k < LANES; k++) begin : gLane
        sbox_dual uSbox (
            .data_i   (aData_q[8*k +: 8]),
            .mode_i   (aMode_q),
            .result_o (laneOut[8*k +: 8])
        );
    end

    // Stage updates: A refills on an input transfer, B refills from A or empties on output
    always_comb begin
        aValid_d = aValid_q;
        aMode_d  = aMode_q;
        aData_d  = aData_q;
        aTag_d   = aTag_q;
        bValid_d = bValid_q;
        bData_d  = bData_q;
        bTag_d   = bTag_q;

        if (aToB) begin
            aValid_d = 1'b0;
        end
        if (inFire) begin
            aValid_d = 1'b1;
            aMode_d  = mode_e'(bus.in_mode);
            aData_d  = bus.in_data;
            aTag_d   = bus.in_tag;
        end

        if (bus.out_ready) begin
            bValid_d = 1'b0;
        end
        if (aToB) begin
            bValid_d = 1'b1;
            bData_d  = laneOut;
            bTag_d   = aTag_q;
        end
    end

    // Pipeline registers; reset drops every in-flight transaction and zeroes the output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aValid_q <= 1'b0;
            aMode_q  <= MODE_FWD;
            aData_q  <= '0;
            aTag_q   <= '0;
            bValid_q <= 1'b0;
            bData_q  <= '0;
            bTag_q   <= '0;
        end else begin
            aValid_q <= aValid_d;
            aMode_q  <= aMode_d;
            aData_q  <= aData_d;
            aTag_q   <= aTag_d;
            bValid_q <= bValid_d;
            bData_q  <= bData_d;
            bTag_q   <= bTag_d;
        end
    end

    assign bus.in_ready  = aReady;
    assign bus.out_valid = bValid_q;
    assign bus.out_data  = bData_q;
    assign bus.out_tag   = bTag_q;
    assign bus.busy      = aValid_q || bValid_q;

endmodule

// File: tb/tb_sbox_lane_pipe.sv
// tb_sbox_lane_pipe: directed checks of the S-box lane pipeline with
// hand-computed AES substitution results.
module tb_sbox_lane_pipe;
    localparam int LANES = 16;
    localparam int TAG_W = 4;
    localparam int DW    = 8 * LANES;

    // Four-lane patterns repeated across all 16 lanes (lane 0 in the low byte)
    localparam logic [DW-1:0] FWD_PAT_IN  = {4{32'hFF530100}};
    localparam logic [DW-1:0] FWD_PAT_EXP = {4{32'h16ED7C63}};
    localparam logic [DW-1:0] INV_PAT_IN  = {4{32'h7CED0063}};
    localparam logic [DW-1:0] INV_PAT_EXP = {4{32'h01535200}};

    logic clk = 1'b0;
    logic rst_n;
    int   checkCount = 0;
    int   passCount  = 0;

    logic             txMode [64];
    logic [DW-1:0]    txData [64];
    logic [TAG_W-1:0] txTag  [64];
    int               txCount;
    logic [DW-1:0]    rxData [64];
    logic [TAG_W-1:0] rxTag  [64];
    int               rxCount;

    always #5 clk = ~clk;

    sbox_lane_pipe_if #(.LANES(LANES), .TAG_W(TAG_W)) bus ();

    sbox_lane_pipe #(.LANES(LANES), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams tx* with out_ready high, capturing every output transfer into rx*
    task automatic applyStimulus(input int budget, output int cycles);
        int sent = 0;
        rxCount = 0;
        cycles  = 0;
        bus.out_ready = 1'b1;
        while (rxCount < txCount && rxCount < 64 && cycles < budget) begin
            if (sent < txCount) begin
                bus.in_valid = 1'b1;
                bus.in_mode  = txMode[sent];
                bus.in_data  = txData[sent];
                bus.in_tag   = txTag[sent];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.out_valid === 1'b1) begin
                rxData[rxCount] = bus.out_data;
                rxTag[rxCount]  = bus.out_tag;
                rxCount++;
            end
            if (bus.in_valid && bus.in_ready === 1'b1) sent++;
            tick();
            cycles++;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_mode   = 1'b0;
        bus.in_data   = {DW{1'b1}};
        bus.in_tag    = '1;
        bus.out_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkCount++;
        if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        else passCount++;
        checkCount++;
        if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy);
        else passCount++;
        checkCount++;
        if ({bus.out_tag, bus.out_data} !== '0) $display("[TB] FAIL reset_out_zero: got %h/%h expected 0", bus.out_tag, bus.out_data);
        else passCount++;
        checkCount++;
        if (bus.in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        else passCount++;
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        checkCount++;
        if ({bus.busy, bus.out_valid} !== 2'b00) $display("[TB] FAIL reset_no_capture: got busy/valid %b expected 00", {bus.busy, bus.out_valid});
        else passCount++;
    endtask

    task automatic test_latency_zero();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_mode   = 1'b0;
        bus.in_data   = '0;
        bus.in_tag    = 4'h5;
        #1;
        checkCount++;
        if (bus.in_ready !== 1'b1) $display("[TB] FAIL zero_in_ready: got %b expected 1", bus.in_ready);
        else passCount++;
        tick();
        bus.in_valid = 1'b0;
        #1;
        checkCount++;
        if ({bus.out_valid, bus.busy} !== 2'b01) $display("[TB] FAIL zero_stage_a: got valid/busy %b expected 01", {bus.out_valid, bus.busy});
        else passCount++;
        tick();
        checkCount++;
        if ({bus.out_valid, bus.out_tag, bus.out_data} !== {1'b1, 4'h5, {LANES{8'h63}}})
            $display("[TB] FAIL zero_output: got %b/%h/%h expected 1/5/%h", bus.out_valid, bus.out_tag, bus.out_data, {LANES{8'h63}});
        else passCount++;
        tick();
        checkCount++;
        if ({bus.out_valid, bus.busy} !== 2'b00) $display("[TB] FAIL zero_drained: got valid/busy %b expected 00", {bus.out_valid, bus.busy});
        else passCount++;
    endtask

    task automatic test_patterns();
        logic             pMode [2] = '{1'b1, 1'b0};
        logic [DW-1:0]    pIn   [2] = '{INV_PAT_IN, FWD_PAT_IN};
        logic [DW-1:0]    pExp  [2] = '{INV_PAT_EXP, FWD_PAT_EXP};
        logic [TAG_W-1:0] pTag  [2] = '{4'hA, 4'h3};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_mode  = pMode[i];
            bus.in_data  = pIn[i];
            bus.in_tag   = pTag[i];
            tick();
            bus.in_valid = 1'b0;
            tick();
            checkCount++;
            if ({bus.out_valid, bus.out_tag, bus.out_data} !== {1'b1, pTag[i], pExp[i]})
                $display("[TB] FAIL pattern_%0d: got %b/%h/%h expected 1/%h/%h", i, bus.out_valid, bus.out_tag, bus.out_data, pTag[i], pExp[i]);
            else passCount++;
            tick();
        end
    endtask

    task automatic test_alternating();
        int cycles;
        logic [DW-1:0] expData;
        txCount = 8;
        for (int i = 0; i < 8; i++) begin
            txMode[i] = i[0];
            txData[i] = i[0] ? INV_PAT_IN : FWD_PAT_IN;
            txTag[i]  = TAG_W'(i);
        end
        applyStimulus(40, cycles);
        checkCount++;
        if (rxCount !== 8) $display("[TB] FAIL alt_count: got %0d expected 8", rxCount);
        else passCount++;
        checkCount++;
        if (cycles !== 10) $display("[TB] FAIL alt_throughput: got %0d cycles expected 10", cycles);
        else passCount++;
        for (int i = 0; i < 8; i++) begin
            expData = i[0] ? INV_PAT_EXP : FWD_PAT_EXP;
            checkCount++;
            if ({rxTag[i], rxData[i]} !== {TAG_W'(i), expData})
                $display("[TB] FAIL alt_out_%0d: got %h/%h expected %h/%h", i, rxTag[i], rxData[i], TAG_W'(i), expData);
            else passCount++;
        end
    endtask

    task automatic test_back_pressure();
        logic [7:0] sIn  [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        logic [7:0] sExp [4] = '{8'h7C, 8'h77, 8'h7B, 8'hF2};
        int sent   = 0;
        int got    = 0;
        int cycles = 0;
        int extra  = 0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.in_mode  = 1'b0;
            bus.in_data  = {LANES{sIn[sent]}};
            bus.in_tag   = TAG_W'(sent + 1);
            #1;
            checkCount++;
            if (bus.in_ready !== (c < 2)) $display("[TB] FAIL stall_in_ready_%0d: got %b expected %b", c, bus.in_ready, c < 2);
            else passCount++;
            if (c >= 2) begin
                checkCount++;
                if ({bus.out_valid, bus.out_tag, bus.out_data} !== {1'b1, TAG_W'(1), {LANES{sExp[0]}}})
                    $display("[TB] FAIL stall_hold_%0d: got %b/%h/%h expected 1/1/%h", c, bus.out_valid, bus.out_tag, bus.out_data, {LANES{sExp[0]}});
                else passCount++;
            end
            if (bus.in_ready === 1'b1 && sent < 3) sent++;
            tick();
        end
        checkCount++;
        if (sent !== 2) $display("[TB] FAIL stall_absorbed: got %0d expected 2", sent);
        else passCount++;
        bus.out_ready = 1'b1;
        while (got < 4 && cycles < 30) begin
            if (sent < 4) begin
                bus.in_valid = 1'b1;
                bus.in_data  = {LANES{sIn[sent]}};
                bus.in_tag   = TAG_W'(sent + 1);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.out_valid === 1'b1) begin
                checkCount++;
                if ({bus.out_tag, bus.out_data} !== {TAG_W'(got + 1), {LANES{sExp[got]}}})
                    $display("[TB] FAIL drain_out_%0d: got %h/%h expected %h/%h", got, bus.out_tag, bus.out_data, TAG_W'(got + 1), {LANES{sExp[got]}});
                else passCount++;
                got++;
            end
            if (bus.in_valid && bus.in_ready === 1'b1) sent++;
            tick();
            cycles++;
        end
        bus.in_valid = 1'b0;
        checkCount++;
        if (got !== 4) $display("[TB] FAIL drain_count: got %0d expected 4", got);
        else passCount++;
        for (int c = 0; c < 3; c++) begin
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) extra++;
            tick();
        end
        checkCount++;
        if (extra !== 0) $display("[TB] FAIL drain_no_duplicate: got %0d extra busy cycles expected 0", extra);
        else passCount++;
    endtask

    task automatic test_reset_midflight();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_mode   = 1'b0;
        bus.in_data   = {LANES{8'hAA}};
        bus.in_tag    = 4'h7;
        tick();
        tick();
        bus.in_valid = 1'b0;
        #1;
        checkCount++;
        if ({bus.out_valid, bus.busy, bus.in_ready} !== 3'b110) $display("[TB] FAIL midrst_full: got valid/busy/ready %b expected 110", {bus.out_valid, bus.busy, bus.in_ready});
        else passCount++;
        #1 rst_n = 1'b0;
        #1;
        checkCount++;
        if ({bus.out_valid, bus.busy, bus.in_ready} !== 3'b001) $display("[TB] FAIL midrst_async: got valid/busy/ready %b expected 001", {bus.out_valid, bus.busy, bus.in_ready});
        else passCount++;
        checkCount++;
        if ({bus.out_tag, bus.out_data} !== '0) $display("[TB] FAIL midrst_zero: got %h/%h expected 0", bus.out_tag, bus.out_data);
        else passCount++;
        tick();
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        checkCount++;
        if ({bus.out_valid, bus.busy} !== 2'b00) $display("[TB] FAIL midrst_flushed: got valid/busy %b expected 00", {bus.out_valid, bus.busy});
        else passCount++;
        bus.in_valid = 1'b1;
        bus.in_mode  = 1'b1;
        bus.in_data  = INV_PAT_IN;
        bus.in_tag   = 4'h3;
        tick();
        bus.in_valid = 1'b0;
        #1;
        checkCount++;
        if (bus.out_valid !== 1'b0) $display("[TB] FAIL midrst_early: got %b expected 0", bus.out_valid);
        else passCount++;
        tick();
        checkCount++;
        if ({bus.out_valid, bus.out_tag, bus.out_data} !== {1'b1, 4'h3, INV_PAT_EXP})
            $display("[TB] FAIL midrst_output: got %b/%h/%h expected 1/3/%h", bus.out_valid, bus.out_tag, bus.out_data, INV_PAT_EXP);
        else passCount++;
        tick();
    endtask

    task automatic test_exhaustive();
        int cycles;
        logic [DW-1:0] fwdOut [16];
        txCount = 16;
        for (int i = 0; i < 16; i++) begin
            txMode[i] = 1'b0;
            txTag[i]  = TAG_W'(i);
            for (int k = 0; k < LANES; k++) txData[i][8*k +: 8] = 8'(16 * i + k);
        end
        applyStimulus(60, cycles);
        checkCount++;
        if (rxCount !== 16) $display("[TB] FAIL exh_fwd_count: got %0d expected 16", rxCount);
        else passCount++;
        for (int i = 0; i < 16; i++) begin
            fwdOut[i] = rxData[i];
            txMode[i] = 1'b1;
            txData[i] = fwdOut[i];
        end
        applyStimulus(60, cycles);
        checkCount++;
        if (rxCount !== 16) $display("[TB] FAIL exh_inv_count: got %0d expected 16", rxCount);
        else passCount++;
        for (int x = 0; x < 256; x++) begin
            checkCount++;
            if (rxData[x / 16][8*(x % 16) +: 8] !== 8'(x))
                $display("[TB] FAIL exh_roundtrip_%0d: got %h expected %h", x, rxData[x / 16][8*(x % 16) +: 8], 8'(x));
            else passCount++;
        end
    endtask

    initial begin
        test_reset();
        test_latency_zero();
        test_patterns();
        test_alternating();
        test_back_pressure();
        test_reset_midflight();
        test_exhaustive();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/sbox_lane_pipe.md
SBOX_LANE_PIPE -- requirements
Module: sbox_lane_pipe

Interface
REQ-001 The block SHALL have parameter LANES, default 16, meaning the number of byte lanes processed per transaction (legal range 1..32).
REQ-002 The block SHALL have parameter TAG_W, default 4, meaning the width of the sideband tag carried unchanged with each transaction (legal range 1..16).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an input transaction is present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the input transaction this cycle.
REQ-007 The block SHALL have port in_mode, input, 1 bit: 0 = forward SubBytes table, 1 = inverse InvSubBytes table.
REQ-008 The block SHALL have port in_data, input, 8*LANES bits: lane k occupies bits [8k+7:8k].
REQ-009 The block SHALL have port in_tag, input, TAG_W bits: sideband tag.
REQ-010 The block SHALL have port out_valid, output, 1 bit: an output transaction is present.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts the output transaction.
REQ-012 The block SHALL have port out_data, output, 8*LANES bits: substituted bytes, with lane mapping identical to in_data.
REQ-013 The block SHALL have port out_tag, output, TAG_W bits: the tag of the transaction on out_data.
REQ-014 The block SHALL have port busy, output, 1 bit: at least one pipeline stage holds a valid transaction.

Function
REQ-015 A transfer SHALL occur on a port on each rising edge at which that port's valid and ready are both high.
REQ-016 The block SHALL be a two-stage pipeline.
- Stage A registers in_data, in_mode and in_tag on an input transfer.
- Stage B registers the per-lane lookup of stage A.
REQ-017 Output byte k SHALL equal FWD_SBOX[A_data byte k] when the captured mode is 0, and INV_SBOX[A_data byte k] when it is 1.
- Every lane SHALL use the same mode.
- Mode SHALL apply per transaction, so back-to-back transactions may alternate modes.
REQ-018 Latency SHALL be 2 cycles: data transferred in at edge N SHALL present out_valid=1 after edge N+1, provided stage B is not stalled.
REQ-019 Ready SHALL follow these rules:
- B_ready = !B_valid | out_ready.
- A_ready = !A_valid | B_ready.
- in_ready = A_ready.
REQ-020 Sustained throughput SHALL be one transaction per cycle while out_ready is held high.
REQ-021 When out_ready is low with both stages full, in_ready SHALL be 0 and out_data/out_tag SHALL hold stable until the output transfer.
REQ-022 A simultaneous output transfer and stage-A-to-B move in the same cycle SHALL lose no transaction and duplicate no transaction.
REQ-023 With in_valid low, a stage A emptied into B SHALL clear A_valid, and no spurious output SHALL appear.
REQ-024 Transaction order SHALL be preserved; out_tag SHALL equal the in_tag of the same transaction.
REQ-025 busy SHALL equal A_valid | B_valid.
REQ-026 The data path SHALL hold no state other than stages A and B; there is no FIFO beyond two entries.

Reset
REQ-027 When rst_n is low, A_valid, B_valid, out_valid and busy SHALL be 0 immediately, asynchronously.
REQ-028 When rst_n is low, out_data and out_tag SHALL be 0.
REQ-029 During reset, in_ready SHALL be 1 combinationally, but no transfer SHALL be captured while rst_n is low.
REQ-030 Assertion of reset mid-operation SHALL discard all in-flight transactions; the first transaction after release SHALL emerge with 2-cycle latency.

Structure
REQ-031 Package aes_pkg SHALL define:
- the 256-entry FWD_SBOX and INV_SBOX byte constants;
- the mode encoding (MODE_FWD=0, MODE_INV=1).
REQ-032 One sub-module, sbox_dual, SHALL be instantiated LANES times.
- It SHALL be purely combinational: an 8-bit byte and a mode bit in, an 8-bit result out.
REQ-033 All registers, the ready logic and busy SHALL reside in sbox_lane_pipe.

Verification
REQ-034 LANES=16, mode 0, all lanes 0x00, out_ready=1 -> after 2 cycles, all lanes 0x63.
REQ-035 Mode 1, lanes 0x63, 0x00, 0xED, 0x7C repeated -> lanes 0x00, 0x52, 0x53, 0x01 repeated.
REQ-036 Alternating modes every cycle for 8 transactions with tags 0..7 -> 8 outputs in order, with tags 0..7 and the correct table applied to each.
REQ-037 out_ready held low for 5 cycles while in_valid=1 -> exactly 2 transactions absorbed, in_ready=0 from the third cycle, out_data stable; after release, all transactions drain with no loss or duplicate.
REQ-038 rst_n pulsed low while both stages are full -> out_valid=0 and busy=0 immediately; the next input emerges 2 cycles after acceptance.
REQ-039 Exhaustive check over all 256 bytes in both modes -> INV(FWD(x)) == x for every x.
